// File: rtl/hb_up2_pkg.sv
// Shared types and defaults for the hb_up2 burst sequencer.
package hb_up2_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH_IN = 2'd1,
    RUN      = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  // Clocks from a registered xin to the matching yout0/yout1 pair at hb_up2.
  localparam int HB_UP2_LATENCY = 6;

  // Zero samples pushed before and after a burst to clear filter history.
  localparam int HB_UP2_FLUSH = 8;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter; sticks at all-ones, cleared only by reset.
module sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc until every bit is set, then hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (inc && (cnt != {W{1'b1}}))
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/hb_up2_ctrl.sv
// Burst sequencer for the hb_up2 x2 interpolator: feeds xin every clock,
// tags real samples through the filter latency and emits a valid-qualified
// output pair stream with saturating status counters.
module hb_up2_ctrl
  import hb_up2_pkg::*;
#(
  parameter int XIN_WIDTH    = 16,
  parameter int YOUT_WIDTH   = 16,
  parameter int DUT_LATENCY  = HB_UP2_LATENCY,
  parameter int FLUSH_CYCLES = HB_UP2_FLUSH,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  s_valid,
  input  logic [XIN_WIDTH-1:0]  s_data,
  output logic                  s_ready,
  output logic [XIN_WIDTH-1:0]  hb_xin,
  input  logic [YOUT_WIDTH-1:0] hb_yout0,
  input  logic [YOUT_WIDTH-1:0] hb_yout1,
  input  logic                  hb_ovf,
  output logic                  m_valid,
  output logic [YOUT_WIDTH-1:0] m_data0,
  output logic [YOUT_WIDTH-1:0] m_data1,
  output logic                  m_ovf,
  output logic                  busy,
  output logic                  underrun,
  output logic [CNT_WIDTH-1:0]  out_cnt,
  output logic [CNT_WIDTH-1:0]  ovf_cnt
);

  // DRAIN must cover both the flush zeros and the tail still inside the filter.
  localparam int DRAIN_CYCLES = FLUSH_CYCLES + DUT_LATENCY;
  localparam int PW           = $clog2(DRAIN_CYCLES + 1);

  state_t                 state, state_nxt;
  logic [PW-1:0]          phase_cnt;
  logic                   stop_pend;
  logic                   stop_eff;
  logic                   tag_in;
  logic [XIN_WIDTH-1:0]   xin_nxt;
  logic [DUT_LATENCY:0]   vld_pipe;
  logic                   tag_al;

  assign stop_eff = stop | stop_pend;
  assign tag_al   = vld_pipe[DUT_LATENCY];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start only counts in IDLE, stop only in RUN (or latched).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = FLUSH_IN;
      FLUSH_IN: if (phase_cnt == PW'(FLUSH_CYCLES - 1)) state_nxt = RUN;
      RUN:      if (stop_eff) state_nxt = DRAIN;
      DRAIN:    if (phase_cnt == PW'(DRAIN_CYCLES - 1)) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output decode: what to present to the filter and the upstream handshake.
  always_comb begin
    s_ready = (state == RUN);
    busy    = (state != IDLE);
    tag_in  = (state == RUN) && s_valid;
    xin_nxt = tag_in ? s_data : '0;
  end

  // Cycles spent in the current state; restarts on every transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     phase_cnt <= '0;
    else if (state_nxt != state) phase_cnt <= '0;
    else if (state != IDLE)      phase_cnt <= phase_cnt + PW'(1);
  end

  // Stop seen before RUN is held so RUN lasts a single cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          stop_pend <= 1'b0;
    else if (state == IDLE && start)  stop_pend <= stop;
    else if (state == FLUSH_IN && stop) stop_pend <= 1'b1;
    else if (state == RUN)            stop_pend <= 1'b0;
  end

  // Sticky underrun; a fresh burst starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         underrun <= 1'b0;
    else if (state == IDLE && start) underrun <= 1'b0;
    else if (state == RUN && !s_valid) underrun <= 1'b1;
  end

  // Filter input register and the tag shift register that rides beside it;
  // vld_pipe[0] lines up with hb_xin, vld_pipe[DUT_LATENCY] with yout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_xin   <= '0;
      vld_pipe <= '0;
    end else begin
      hb_xin   <= xin_nxt;
      vld_pipe <= {vld_pipe[DUT_LATENCY-1:0], tag_in};
    end
  end

  // Output pair register; data only moves on a tagged pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_ovf   <= 1'b0;
      m_data0 <= '0;
      m_data1 <= '0;
    end else begin
      m_valid <= tag_al;
      m_ovf   <= hb_ovf & tag_al;
      if (tag_al) begin
        m_data0 <= hb_yout0;
        m_data1 <= hb_yout1;
      end
    end
  end

  sat_cnt #(.W(CNT_WIDTH)) u_out_cnt (
    .clk (clk),
    .rst (rst),
    .inc (m_valid),
    .cnt (out_cnt)
  );

  sat_cnt #(.W(CNT_WIDTH)) u_ovf_cnt (
    .clk (clk),
    .rst (rst),
    .inc (m_valid & m_ovf),
    .cnt (ovf_cnt)
  );

endmodule

// File: tb/tb_hb_up2_ctrl.sv
// Bench for hb_up2_ctrl: a delay-line filter stub, a scoreboard of expected
// output pairs (value and arrival cycle), table-driven bursts and a few
// hand-written corner sequences.
module tb_hb_up2_ctrl;
  import hb_up2_pkg::*;

  localparam int LAT = HB_UP2_LATENCY;
  localparam int FL  = HB_UP2_FLUSH;
  localparam int DRN = FL + LAT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready;
  logic [15:0] hb_xin, hb_yout0, hb_yout1;
  logic        hb_ovf;
  logic        m_valid, m_ovf, busy, underrun;
  logic [15:0] m_data0, m_data1;
  logic [31:0] out_cnt, ovf_cnt;
  logic        ovf_force = 1'b0;
  logic        sat_inc = 1'b0;
  logic [2:0]  sat_q;

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;
  int pulses = 0;

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    logic        ovf;
    int          cyc;
  } exp_t;
  exp_t q[$];

  typedef struct {
    int          n_cyc;
    int          gap_at;
    int          gap_len;
    logic [15:0] base;
    logic [15:0] step;
    int          imp_at;
    int          exp_pulses;
    logic        exp_unr;
    int          exp_ovf;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Filter stub: pure delay, second phase scrambled, overflow on full-scale.
  logic [15:0] dl [LAT];
  always @(posedge clk) begin
    dl[0] <= hb_xin;
    for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
  end
  assign hb_yout0 = dl[LAT-1];
  assign hb_yout1 = dl[LAT-1] ^ 16'h5A5A;
  assign hb_ovf   = ovf_force | (dl[LAT-1] == 16'h7FFF);

  hb_up2_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .hb_xin(hb_xin), .hb_yout0(hb_yout0), .hb_yout1(hb_yout1), .hb_ovf(hb_ovf),
    .m_valid(m_valid), .m_data0(m_data0), .m_data1(m_data1), .m_ovf(m_ovf),
    .busy(busy), .underrun(underrun), .out_cnt(out_cnt), .ovf_cnt(ovf_cnt)
  );

  sat_cnt #(.W(3)) u_sat (.clk(clk), .rst(rst), .inc(sat_inc), .cnt(sat_q));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard side: compare any output pair on the falling edge.
  task automatic monitor();
    exp_t e;
    if (rst) return;
    if (m_valid) begin
      pulses++;
      if (q.size() == 0) chk("unexpected_m_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("m_data0", m_data0, e.d0);
        chk("m_data1", m_data1, e.d1);
        chk("m_ovf", m_ovf, e.ovf);
        chk("latency", cyc, e.cyc);
      end
    end else if (m_ovf) chk("m_ovf_without_valid", m_ovf, 0);
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] x);
    exp_t e;
    e.d0 = x; e.d1 = x ^ 16'h5A5A; e.ovf = (x == 16'h7FFF); e.cyc = cyc + LAT + 2;
    q.push_back(e);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {s_ready, busy, m_valid, m_ovf, underrun, hb_xin, m_data0, m_data1},
        64'd0);
    chk({nm, "_cnt"}, {out_cnt, ovf_cnt}, 64'd0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!s_ready && n < 50) begin tick(); n++; end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] oc0, vc0;
    int p0, n;
    logic gap;
    logic [15:0] x, last;
    oc0 = out_cnt; vc0 = ovf_cnt; p0 = pulses; last = m_data0;
    start = 1'b1; tick(); start = 1'b0;
    chk("underrun_cleared", underrun, 0);
    wait_ready(n);
    chk("flush_len", n, FL);
    for (int i = 0; i < v.n_cyc; i++) begin
      gap = (v.gap_at >= 0) && (i >= v.gap_at) && (i < v.gap_at + v.gap_len);
      x = (i == v.imp_at) ? 16'h7FFF : v.base + v.step * 16'(i);
      s_valid = !gap;
      s_data  = x;
      stop    = (i == v.n_cyc - 1);
      chk("s_ready_run", s_ready, 1);
      if (!gap) begin push(x); last = x; end
      tick();
      chk("hb_xin", hb_xin, gap ? 16'h0 : x);
    end
    stop = 1'b0; s_valid = 1'b0;
    chk("s_ready_after_stop", s_ready, 0);
    wait_idle(n);
    chk("busy_fall", n, DRN);
    chk("xin_idle", hb_xin, 0);
    tick(); tick();
    chk("pulses", pulses - p0, v.exp_pulses);
    chk("underrun", underrun, v.exp_unr);
    chk("out_cnt_delta", out_cnt - oc0, v.exp_pulses);
    chk("ovf_cnt_delta", ovf_cnt - vc0, v.exp_ovf);
    chk("m_data_hold", m_data0, last);
    chk("sb_empty", q.size(), 0);
  endtask

  initial begin
    int n, p0;
    logic [31:0] oc0, vc0;
    tbl[0] = '{16, -1, 0, 16'h0100, 16'h0000, -1, 16, 1'b0, 0};
    tbl[1] = '{10,  4, 3, 16'h0200, 16'h0001, -1,  7, 1'b1, 0};
    tbl[2] = '{ 5, -1, 0, 16'h1000, 16'h0111, -1,  5, 1'b0, 0};
    tbl[3] = '{ 6, -1, 0, 16'h0000, 16'h0000,  2,  6, 1'b0, 1};
    tbl[4] = '{ 1, -1, 0, 16'hABCD, 16'h0000, -1,  1, 1'b0, 0};

    // Reset held, then idle with no start.
    tick(); tick();
    chk_all_zero("reset_state");
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk_all_zero("idle");
    end

    // Counter saturation on a narrow instance.
    sat_inc = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("sat_count", sat_q, 5);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_hold", sat_q, 7);
    sat_inc = 1'b0;

    for (int t = 0; t < 5; t++) begin
      run_vec(tbl[t]);
      if (t == 0) chk("out_cnt_abs", out_cnt, 16);
    end

    // start+stop together, forced overflow throughout, extra starts ignored.
    oc0 = out_cnt; vc0 = ovf_cnt; p0 = pulses;
    ovf_force = 1'b1;
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 1);
    n = 0;
    while (!s_ready && n < 50) begin
      start = (n == 3);
      tick(); n++;
    end
    start = 1'b0;
    chk("ss_flush_len", n, FL);
    tick();
    chk("ss_run_one", {s_ready, busy}, 2'b01);
    n = 0;
    while (busy && n < 100) begin
      start = (n == 2);
      tick(); n++;
    end
    start = 1'b0;
    chk("ss_drain_len", n, DRN);
    tick(); tick();
    chk("ss_stay_idle", busy, 0);
    ovf_force = 1'b0;
    chk("ss_underrun", underrun, 1);
    chk("ss_no_pulse", pulses - p0, 0);
    chk("ss_out_cnt", out_cnt - oc0, 0);
    chk("ss_ovf_cnt", ovf_cnt - vc0, 0);

    // Reset in the middle of RUN drops every in-flight pair.
    start = 1'b1; tick(); start = 1'b0;
    wait_ready(n);
    chk("mr_flush_len", n, FL);
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 16'h0300 + 16'(i);
      push(s_data);
      tick();
    end
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    q.delete();
    s_valid = 1'b0;
    p0 = pulses;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("mr_no_pulse", pulses - p0, 0);
    run_vec(tbl[0]);
    chk("mr_out_cnt_abs", out_cnt, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

  // Hard stop if something wedges the sequence above.
  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule

// File: doc/hb_up2_ctrl.md
Name: hb_up2_ctrl

Overview:
- Burst sequencer for the hb_up2 half-band x2 interpolator.
- hb_up2 has no clock enable and consumes one xin every clock. This block drives xin each cycle, tracks which outputs are real, and exposes a valid-qualified two-sample output stream with status counters.
- It sits between an upstream sample source and the hb_up2 instance, which is connected by the enclosing wrapper.

Parameters:
- XIN_WIDTH, 16, input/xin sample width
- YOUT_WIDTH, 16, width of yout0/yout1
- DUT_LATENCY, 6, clocks from xin registered to matching yout0/yout1 at the filter
- FLUSH_CYCLES, 8, zero samples fed before and after a burst to clear the filter history (must be ≥1)
- CNT_WIDTH, 32, width of the status counters

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active high
- start  in  1  one-cycle pulse: begin a burst
- stop  in  1  one-cycle pulse: end the burst
- s_valid  in  1  upstream sample valid
- s_data  in  XIN_WIDTH  upstream sample
- s_ready  out  1  high while in RUN
- hb_xin  out  XIN_WIDTH  to filter xin
- hb_yout0  in  YOUT_WIDTH  from filter
- hb_yout1  in  YOUT_WIDTH  from filter
- hb_ovf  in  1  from filter
- m_valid  out  1  output pair valid
- m_data0  out  YOUT_WIDTH  first output sample (time order)
- m_data1  out  YOUT_WIDTH  second output sample
- m_ovf  out  1  overflow flag for this pair
- busy  out  1  state != IDLE
- underrun  out  1  sticky: s_valid low while in RUN
- out_cnt  out  CNT_WIDTH  pairs delivered, saturating
- ovf_cnt  out  CNT_WIDTH  pairs with m_ovf, saturating

Behaviour:
- Reset (async, active high) sets every output to 0: hb_xin, s_ready, m_*, busy, underrun, counters. State goes to IDLE and the valid shift register is cleared.
- FSM states and transitions:
  - IDLE: hb_xin=0. start → FLUSH_IN.
  - FLUSH_IN: hb_xin=0 for FLUSH_CYCLES clocks, then RUN.
  - RUN: s_ready=1. Each clock hb_xin<=s_valid ? s_data : 0. If s_valid=0, set underrun. stop → DRAIN.
  - DRAIN: hb_xin=0 for FLUSH_CYCLES + DUT_LATENCY clocks, then IDLE.
- start is ignored outside IDLE.
- stop is ignored in IDLE. A stop during FLUSH_IN is latched and applied on entry to RUN, so RUN lasts exactly one cycle.
- start and stop in the same cycle while IDLE: the burst starts and stop is latched as above.
- Tag pipeline:
  - A 1-bit tag travels with each hb_xin write. Tag=1 only for RUN cycles with s_valid=1.
  - The tag is delayed DUT_LATENCY+1 clocks (hb_xin register plus filter latency), so it aligns with hb_yout0/1.
- Output register (1 clock):
  - m_valid<=tag, m_data0<=hb_yout0, m_data1<=hb_yout1, m_ovf<=hb_ovf & tag.
  - m_data* hold their last value when m_valid=0.
  - Total latency from s_data accepted to m_valid: DUT_LATENCY+2 clocks.
- Counters:
  - out_cnt increments on m_valid; ovf_cnt increments on m_valid & m_ovf.
  - Both saturate at all-ones and are cleared only by reset.
- underrun is sticky and cleared when the next start is accepted.
- No backpressure: the filter cannot stall, and downstream must accept every m_valid.
- Reset mid-burst: everything is cleared immediately and in-flight tags are discarded.

Decomposition:
- Package hb_up2_pkg holds:
  - typedef enum of FSM states {IDLE, FLUSH_IN, RUN, DRAIN}
  - the DUT_LATENCY default constant shared with hb_up2 benches
  - the FLUSH_CYCLES default constant
- One natural sub-module, sat_cnt (parameterised width, inc input, saturating), instantiated twice for out_cnt and ovf_cnt.
- The tag delay line and FSM stay inline.

Test Plan:
- Reset held, then released with no start → all outputs 0, busy=0, hb_xin=0 for 100 clocks.
- start; after 8 flush clocks feed 16 continuous samples 0x0100; stop → s_ready high for exactly 16 accepted cycles, then 16 m_valid pulses starting DUT_LATENCY+2=8 clocks after the first accept. out_cnt=16, busy falls 14 clocks after stop.
- During RUN drop s_valid for 3 cycles within 10 samples → underrun=1, exactly 7 m_valid pulses, and hb_xin=0 in the 3 gap cycles.
- Impulse 0x7FFF with hb_ovf forced to 1 on its aligned cycle → m_ovf=1 on that pair only, ovf_cnt=1. hb_ovf forced high during FLUSH/DRAIN → ovf_cnt unchanged.
- start+stop in the same cycle in IDLE → 8 flush clocks, 1 RUN clock, 14 DRAIN clocks, then IDLE. start pulses while busy are ignored.
- Assert rst mid-RUN after 5 samples → all outputs 0 within the same cycle, no m_valid afterwards. A new burst then behaves as in scenario 2.
